// File: rtl/rng_pkg.sv
// Shared types and defaults for the ring-oscillator entropy collector.
// Imported by rng_collector.
package rng_pkg;

  typedef enum logic {
    PAIR0 = 1'b0,
    PAIR1 = 1'b1
  } vn_state_t;

  localparam int SYNC_DEF      = 2;
  localparam int DIV_W_DEF     = 8;
  localparam int OUT_W_DEF     = 8;
  localparam int REP_LIMIT_DEF = 32;
  localparam int REP_W         = 8;

  localparam logic [REP_W-1:0] REP_MAX = '1;

  function automatic logic [REP_W-1:0] rep_inc(
    input logic [REP_W-1:0] c
  );
    return (c == REP_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// The first flop may go metastable; only the last stage is used.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rng_collector.sv
// Entropy collector: sync, sample divider, von Neumann debias,
// byte packing, valid/ready output and repetition health test.
module rng_collector
  import rng_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_DEF,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int OUT_W       = OUT_W_DEF,
  parameter int REP_LIMIT   = REP_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rnd_in,
  input  logic             en,
  input  logic             vn_en,
  input  logic [DIV_W-1:0] div,
  input  logic             clr_flags,
  input  logic             data_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             data_valid,
  output logic             overrun,
  output logic             stuck
);

  localparam int CNT_W = $clog2(OUT_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OUT_W - 1);
  localparam logic [REP_W-1:0] REP_LIM = REP_W'(REP_LIMIT);

  logic s;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rnd_in),
    .q    (s)
  );

  logic [DIV_W-1:0] cnt_q, cnt_d;
  vn_state_t        vn_q, vn_d;
  logic             a_q, a_d;
  logic             vn_en_q, vn_en_d;
  logic [OUT_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             last_q, last_d;
  logic [OUT_W-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             overrun_q, overrun_d;
  logic             stuck_q, stuck_d;

  logic             tick;
  logic             accept;
  logic             bit_v;
  logic             complete;
  logic [OUT_W-1:0] word;
  vn_state_t        vn_eff;
  logic             ov_set;
  logic             st_set;
  logic             load;
  logic             drop;
  logic             free;

  always_comb begin
    cnt_d        = cnt_q;
    vn_d         = vn_q;
    a_d          = a_q;
    vn_en_d      = vn_en;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    rep_d        = rep_q;
    last_d       = last_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    tick         = 1'b0;
    accept       = 1'b0;
    bit_v        = s;
    complete     = 1'b0;
    word         = shift_q;
    ov_set       = 1'b0;
    st_set       = 1'b0;
    // A vn_en toggle restarts pairing from the current sample
    vn_eff       = (vn_en != vn_en_q) ? PAIR0 : vn_q;
    vn_d         = vn_eff;

    if (!en) begin
      cnt_d     = '0;
      vn_d      = PAIR0;
      a_d       = 1'b0;
      shift_d   = '0;
      bit_cnt_d = '0;
      rep_d     = '0;
      last_d    = 1'b0;
    end else begin
      tick  = (cnt_q == div);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        rep_d  = (s == last_q) ? rep_inc(rep_q) : REP_W'(1);
        last_d = s;
        st_set = (rep_d >= REP_LIM);
        if (!vn_en) begin
          accept = 1'b1;
          bit_v  = s;
        end else begin
          unique case (vn_eff)
            PAIR0: begin
              a_d  = s;
              vn_d = PAIR1;
            end
            PAIR1: begin
              accept = (a_q != s);
              bit_v  = a_q;
              vn_d   = PAIR0;
            end
            default: ;
          endcase
        end
      end
      if (accept) begin
        word    = {shift_q[OUT_W-2:0], bit_v};
        shift_d = word;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          complete  = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    end

    load = complete & (~data_valid_q | data_ready);
    drop = complete & data_valid_q & ~data_ready;
    free = ~complete & data_valid_q & data_ready;

    unique case (1'b1)
      load: begin
        data_out_d   = word;
        data_valid_d = 1'b1;
      end
      drop: ov_set = 1'b1;
      free: data_valid_d = 1'b0;
      default: ;
    endcase

    overrun_d = ov_set | (overrun_q & ~clr_flags);
    stuck_d   = st_set | (stuck_q & ~clr_flags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      vn_q         <= PAIR0;
      a_q          <= 1'b0;
      vn_en_q      <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      rep_q        <= '0;
      last_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      vn_q         <= vn_d;
      a_q          <= a_d;
      vn_en_q      <= vn_en_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      rep_q        <= rep_d;
      last_q       <= last_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
      stuck_q      <= stuck_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;
  assign stuck      = stuck_q;

endmodule
